// File: rtl/digit_serial_adder_if.sv
// Bus bundle for the digit-serial adder: operand/request inputs and
// the busy/done/result outputs travel together between requester and adder.
interface digit_serial_adder_if #(
  parameter int WIDTH = 8
) ();

  logic             start;
  logic             inv_a;
  logic             inv_b;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  // Requester side: issues operands, observes progress and result.
  modport master (
    output start, inv_a, inv_b, a, b, cin,
    input  busy, done, sum, cout
  );

  // Adder side: consumes operands, produces progress and result.
  modport slave (
    input  start, inv_a, inv_b, a, b, cin,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/digit_serial_adder.sv
// Digit-serial ripple-carry adder: adds two WIDTH-bit operands DIGIT bits
// per clock, carrying between digits in a register. Optional per-operand
// inversion, start/busy/done handshake, result held until the next done.
module digit_serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  digit_serial_adder_if.slave  bus
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CNTW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int DW   = DIGIT + 1;
  localparam logic [CNTW-1:0] LAST_DIG = CNTW'(NDIG - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;

  // Per-digit views of the latched operands.
  logic [DIGIT-1:0] opa_dig [NDIG];
  logic [DIGIT-1:0] opb_dig [NDIG];

  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_dig
      assign opa_dig[gi] = opa_q[gi*DIGIT +: DIGIT];
      assign opb_dig[gi] = opb_q[gi*DIGIT +: DIGIT];
    end
  endgenerate

  logic [DIGIT-1:0] cur_a;
  logic [DIGIT-1:0] cur_b;
  logic [DW-1:0]    dig_res;

  // Select the current digit and add it with the stored carry.
  always_comb begin
    cur_a = '0;
    cur_b = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (cnt_q == CNTW'(i)) begin
        cur_a = opa_dig[i];
        cur_b = opb_dig[i];
      end
    end
    dig_res = {1'b0, cur_a} + {1'b0, cur_b} + DW'(carry_q);
  end

  // Next-state and datapath update: accept, digit step, completion.
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    work_d  = work_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          opa_d   = bus.inv_a ? ~bus.a : bus.a;
          opb_d   = bus.inv_b ? ~bus.b : bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          work_d  = '0;
          state_d = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end

      RUN: begin
        for (int i = 0; i < NDIG; i++) begin
          if (cnt_q == CNTW'(i)) begin
            work_d[i*DIGIT +: DIGIT] = dig_res[DIGIT-1:0];
          end
        end
        carry_d = dig_res[DIGIT];
        if (cnt_q == LAST_DIG) begin
          // Publish the whole result at once; the counter parks on the
          // last digit instead of wrapping.
          sum_d   = work_d;
          cout_d  = dig_res[DIGIT];
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Self-checking bench for digit_serial_adder: an 8-bit/2-bit-digit instance
// and a 2-bit/1-bit-digit instance, checked against plain-arithmetic sums.
module tb_digit_serial_adder;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  digit_serial_adder_if #(.WIDTH(8)) bus8 ();
  digit_serial_adder_if #(.WIDTH(2)) bus2 ();

  digit_serial_adder #(.WIDTH(8), .DIGIT(2)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  digit_serial_adder #(.WIDTH(2), .DIGIT(1)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected result held by the bench for each instance.
  logic [7:0] exp_sum8;
  logic       exp_cout8;
  logic [1:0] exp_sum2;
  logic       exp_cout2;

  function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b,
                                        input logic ia, input logic ib, input logic ci);
    int unsigned oa, ob;
    oa = ia ? (255 - a) : a;
    ob = ib ? (255 - b) : b;
    return 9'((oa + ob + ci) % 512);
  endfunction

  function automatic logic [2:0] model2(input logic [1:0] a, input logic [1:0] b,
                                        input logic ia, input logic ib, input logic ci);
    int unsigned oa, ob;
    oa = ia ? (3 - a) : a;
    ob = ib ? (3 - b) : b;
    return 3'((oa + ob + ci) % 8);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set8(input logic [7:0] a, input logic [7:0] b,
                      input logic ia, input logic ib, input logic ci);
    bus8.a = a; bus8.b = b; bus8.inv_a = ia; bus8.inv_b = ib; bus8.cin = ci;
  endtask

  // One full 8-bit transaction with per-cycle handshake checks.
  // Ends at the negedge of the done cycle.
  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      input logic ia, input logic ib, input logic ci,
                      input bit scramble, input string tag);
    logic [8:0] r;
    r = model8(a, b, ia, ib, ci);
    @(posedge clk); #1;
    set8(a, b, ia, ib, ci);
    bus8.start = 1'b1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (scramble) set8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      @(negedge clk);
      check({tag, "_busy"}, 32'(bus8.busy), 32'd1);
      check({tag, "_nodone"}, 32'(bus8.done), 32'd0);
      check({tag, "_hold"}, {23'd0, bus8.cout, bus8.sum}, {23'd0, exp_cout8, exp_sum8});
      @(posedge clk); #1;
    end
    @(negedge clk);
    exp_sum8  = r[7:0];
    exp_cout8 = r[8];
    check({tag, "_done"}, 32'(bus8.done), 32'd1);
    check({tag, "_idle"}, 32'(bus8.busy), 32'd0);
    check({tag, "_result"}, {23'd0, bus8.cout, bus8.sum}, {23'd0, exp_cout8, exp_sum8});
    $display("txn w8 %s a=%h b=%h inv_a=%b inv_b=%b cin=%b -> sum=%h cout=%b",
             tag, a, b, ia, ib, ci, bus8.sum, bus8.cout);
  endtask

  // One full 2-bit transaction: busy in cycles 1..2, done in cycle 3.
  task automatic run2(input logic [1:0] a, input logic [1:0] b,
                      input logic ia, input logic ib, input logic ci, input string tag);
    logic [2:0] r;
    r = model2(a, b, ia, ib, ci);
    @(posedge clk); #1;
    bus2.a = a; bus2.b = b; bus2.inv_a = ia; bus2.inv_b = ib; bus2.cin = ci;
    bus2.start = 1'b1;
    @(posedge clk); #1;
    bus2.start = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      check({tag, "_busy"}, 32'(bus2.busy), 32'd1);
      check({tag, "_nodone"}, 32'(bus2.done), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    exp_sum2  = r[1:0];
    exp_cout2 = r[2];
    check({tag, "_done"}, 32'(bus2.done), 32'd1);
    check({tag, "_result"}, {29'd0, bus2.cout, bus2.sum}, {29'd0, exp_cout2, exp_sum2});
    $display("txn w2 %s a=%b b=%b inv_a=%b inv_b=%b cin=%b -> sum=%b cout=%b",
             tag, a, b, ia, ib, ci, bus2.sum, bus2.cout);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] ra;
    logic [8:0] rc;
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus8.start = 1'b0; set8(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    bus2.start = 1'b0; bus2.a = '0; bus2.b = '0;
    bus2.inv_a = 1'b0; bus2.inv_b = 1'b0; bus2.cin = 1'b0;
    exp_sum8 = '0; exp_cout8 = 1'b0; exp_sum2 = '0; exp_cout2 = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy8", 32'(bus8.busy), 32'd0);
    check("rst_done8", 32'(bus8.done), 32'd0);
    check("rst_res8", {23'd0, bus8.cout, bus8.sum}, 32'd0);
    check("rst_busy2", 32'(bus2.busy), 32'd0);
    check("rst_done2", 32'(bus2.done), 32'd0);
    check("rst_res2", {29'd0, bus2.cout, bus2.sum}, 32'd0);

    // Directed arithmetic cases.
    run8(8'h5A, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, "basic");
    check("basic_const", {23'd0, bus8.cout, bus8.sum}, 32'h08D);
    run8(8'hFF, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "ripple_cin");
    check("ripple_cin_const", {23'd0, bus8.cout, bus8.sum}, 32'h100);
    run8(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, "ripple_b");
    run8(8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, "inv_ab");
    check("inv_ab_const", {23'd0, bus8.cout, bus8.sum}, 32'h1FE);
    run8(8'h0F, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0, "inv_a");
    run8(8'hA5, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, "inv_b");

    // Start during RUN is ignored; start in the DONE cycle is accepted.
    ra = model8(8'h12, 8'h34, 1'b0, 1'b0, 1'b1);
    rc = model8(8'hC8, 8'h77, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    set8(8'h12, 8'h34, 1'b0, 1'b0, 1'b1); bus8.start = 1'b1;       // cycle 0
    @(posedge clk); #1 bus8.start = 1'b0;                          // cycle 1
    @(posedge clk); #1;
    set8(8'hEE, 8'hEE, 1'b1, 1'b1, 1'b1); bus8.start = 1'b1;       // cycle 2
    @(posedge clk); #1 bus8.start = 1'b0;                          // cycle 3
    @(posedge clk);                                                // cycle 4
    @(posedge clk); #1;                                            // cycle 5
    set8(8'hC8, 8'h77, 1'b1, 1'b0, 1'b0); bus8.start = 1'b1;
    @(negedge clk);
    exp_sum8 = ra[7:0]; exp_cout8 = ra[8];
    check("b2b_done1", 32'(bus8.done), 32'd1);
    check("b2b_res1", {23'd0, bus8.cout, bus8.sum}, {23'd0, ra});
    $display("txn w8 b2b_first sum=%h cout=%b", bus8.sum, bus8.cout);
    @(posedge clk); #1 bus8.start = 1'b0;                          // cycle 6
    @(negedge clk);
    check("b2b_busy2", 32'(bus8.busy), 32'd1);
    check("b2b_hold", {23'd0, bus8.cout, bus8.sum}, {23'd0, ra});
    repeat (3) @(posedge clk);                                     // cycle 9
    @(negedge clk);
    check("b2b_nodone9", 32'(bus8.done), 32'd0);
    @(posedge clk);                                                // cycle 10
    @(negedge clk);
    exp_sum8 = rc[7:0]; exp_cout8 = rc[8];
    check("b2b_done2", 32'(bus8.done), 32'd1);
    check("b2b_res2", {23'd0, bus8.cout, bus8.sum}, {23'd0, rc});
    $display("txn w8 b2b_second sum=%h cout=%b", bus8.sum, bus8.cout);

    // Reset in cycle 3 of an operation aborts it.
    @(posedge clk); #1;
    set8(8'h77, 8'h99, 1'b0, 1'b0, 1'b1); bus8.start = 1'b1;       // cycle 0
    @(posedge clk); #1 bus8.start = 1'b0;                          // cycle 1
    @(posedge clk);                                                // cycle 2
    @(posedge clk); #1 rst = 1'b1;                                 // cycle 3
    @(posedge clk); #1 rst = 1'b0;                                 // cycle 4
    @(negedge clk);
    exp_sum8 = '0; exp_cout8 = 1'b0;
    check("abort_busy", 32'(bus8.busy), 32'd0);
    check("abort_done", 32'(bus8.done), 32'd0);
    check("abort_res", {23'd0, bus8.cout, bus8.sum}, 32'd0);
    for (int k = 5; k <= 8; k++) begin
      @(negedge clk);
      check("abort_nodone", 32'(bus8.done), 32'd0);
    end
    $display("txn w8 abort after reset");
    exp_sum2 = '0; exp_cout2 = 1'b0;
    run8(8'h80, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0, "post_rst");

    // Randomised operands, with inputs scrambled while the adder runs.
    for (int t = 0; t < 20; t++) begin
      run8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           1'b1, "rand");
    end

    // Exhaustive 2-bit, 1-bit digit, both operands inverted.
    for (int i = 0; i < 16; i++) begin
      run2(2'(i / 4), 2'(i % 4), 1'b1, 1'b1, 1'b0, "w2_inv");
    end
    for (int t = 0; t < 6; t++) begin
      run2(2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), "w2_rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/digit_serial_adder.md
Name: digit_serial_adder

Overview:
Parametrised multi-cycle ripple-carry adder. Adds two WIDTH-bit operands DIGIT bits per clock, keeping the carry in a register between digits.
- Per-operand inversion modes compute ~a + ~b, a + ~b, etc., for the inverted-input adder variants.
- Start/busy/done handshake, so the block sits on a shared datapath as a time-multiplexed replacement for wide combinational adders.

Parameters:
WIDTH, 8, operand and sum width in bits; must be a multiple of DIGIT.
DIGIT, 2, bits added per clock cycle; 1 <= DIGIT <= WIDTH.
NDIG, WIDTH/DIGIT, derived digit count; not overridable.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request a new addition; sampled only when accepting (IDLE or DONE).
inv_a  input  1  1: operand A is ~a. Latched at accept.
inv_b  input  1  1: operand B is ~b. Latched at accept.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry-in to digit 0. Latched at accept.
busy  output  1  high while digits are being processed.
done  output  1  one-cycle pulse; sum/cout valid and newly updated.
sum  output  WIDTH  result bits [WIDTH-1:0]; holds until next done.
cout  output  1  carry-out of MSB; holds until next done.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Internal operand, carry and digit-counter registers are cleared.
  - Reset mid-operation aborts the operation; no done is produced for it.
- States: IDLE, RUN, DONE.
  - busy = (state==RUN).
  - done = (state==DONE).
- Accept: in IDLE or DONE with start=1 at an edge:
  - Latch opA = inv_a ? ~a : a, and opB = inv_b ? ~b : b.
  - carry = cin, cnt = 0, state -> RUN.
- Start handling outside accept:
  - start in RUN is ignored; it is not queued.
  - In DONE with start=0, state -> IDLE.
- RUN, each edge:
  - Digit d = cnt covers bits [d*DIGIT +: DIGIT].
  - {c, s} = opA_d + opB_d + carry, using (DIGIT+1)-bit arithmetic.
  - Write s into the working-sum digit d; carry <= c; cnt <= cnt+1.
  - On the edge processing cnt==NDIG-1:
    - sum <= the complete working sum, including this final digit.
    - cout <= c.
    - state -> DONE.
- Latency:
  - start high in cycle 0 gives busy high in cycles 1..NDIG and done high in cycle NDIG+1.
  - Throughput is one result per NDIG+1 cycles, with back-to-back starts accepted in the DONE cycle.
- Arithmetic:
  - The result equals (opA + opB + cin) mod 2^(WIDTH+1), split as {cout, sum}.
  - This is identical to a WIDTH-bit ripple-carry adder on the post-inversion operands.
- Boundaries:
  - DIGIT==WIDTH: NDIG=1, one RUN cycle.
  - cnt width is max(1, clog2(NDIG)); it never wraps past NDIG-1.
  - a/b/inv/cin changes after accept have no effect.
- sum/cout are updated only at the transition into DONE. They are never partially updated while visible.

Test Plan:
- WIDTH=8, DIGIT=2, a=0x5A, b=0x33, cin=0, no inversion, start in cycle 0 -> busy in cycles 1-4; done in cycle 5 with sum=0x8D, cout=0.
- a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1 (carry ripples through all 4 digits). Then a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1.
- inv_a=1, inv_b=1, a=0x00, b=0x00, cin=0 -> 0xFF+0xFF gives sum=0xFE, cout=1. inv_a=1 only, a=0x0F, b=0x10 -> 0xF0+0x10 gives sum=0x00, cout=1.
- Start at cycle 0; pulse start with new operands in cycle 2 -> ignored; the done at cycle 5 carries the first result. A second start in cycle 5 is accepted -> next done in cycle 10.
- rst=1 in cycle 3 of an operation -> cycle 4: busy=0, done=0, sum=0, cout=0. No done pulse follows; a new start completes normally.
- WIDTH=2, DIGIT=1, inv_a=inv_b=1, cin=0, all 16 a/b combinations -> sum[0]=~a0^~b0 and sum[1]=~a1^~b1^(~a0&~b0). cout = (~a1&~b1) | ((~a0&~b0)&(~a1^~b1)). done arrives 3 cycles after start.
